// File: rtl/bin_to_onehot_decoder_pkg.sv
// Shared defaults and decode helpers for the binary-to-one-hot decoder.
// The bench uses the same helpers.
package onehot_pkg;

  localparam int BIN_W_DEF  = 3;
  localparam int OUT_W_DEF  = 8;
  localparam int ONEHOT_MAX = 256;

  // An X/Z index yields X from the equality compare, which is the intended simulation behaviour.
  function automatic logic [ONEHOT_MAX-1:0] onehot_decode(input logic [7:0] bin,
                                                          input int unsigned out_w);
    logic [ONEHOT_MAX-1:0] res;
    res = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      if (i < int'(out_w)) res[i] = (bin == 8'(i));
    end
    return res;
  endfunction

  function automatic logic is_onehot(input logic [ONEHOT_MAX-1:0] vec);
    return ($countones(vec) == 1);
  endfunction

endpackage

// File: rtl/bin_to_onehot_decoder_if.sv
// Index/strobe bundle between a controller and the one-hot decoder.
interface bin_to_onehot_decoder_if
  import onehot_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int OUT_W = 2**BIN_W
);
  logic [BIN_W-1:0] Bin;
  logic             en;
  logic [OUT_W-1:0] OneHotCode;
  logic             range_err;
  logic [OUT_W-1:0] OneHotCode_q;
  logic             valid_q;
  logic             err_q;

  modport master (
    output Bin, en,
    input  OneHotCode, range_err, OneHotCode_q, valid_q, err_q
  );

  modport slave (
    input  Bin, en,
    output OneHotCode, range_err, OneHotCode_q, valid_q, err_q
  );
endinterface

// File: rtl/bin_to_onehot_decoder_comb.sv
// Parameterized combinational binary-to-one-hot decoder with out-of-range flag.
module onehot_decode_comb
  import onehot_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int OUT_W = 2**BIN_W
) (
  input  logic [BIN_W-1:0] bin_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             range_err_o
);

  always_comb begin
    onehot_o    = OUT_W'(onehot_decode(8'(bin_i), OUT_W));
    range_err_o = ($unsigned(32'(bin_i)) >= $unsigned(32'(OUT_W)));
  end

endmodule

// File: rtl/bin_to_onehot_decoder.sv
// One-hot decoder: zero-latency decode plus an enable-qualified registered copy.
module bin_to_onehot_decoder
  import onehot_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int OUT_W = 2**BIN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bin_to_onehot_decoder_if.slave  bus
);

  if (BIN_W < 1 || BIN_W > 8 || OUT_W < 2 || OUT_W > 2**BIN_W) begin : g_bad_params
    $error("bin_to_onehot_decoder: illegal BIN_W=%0d / OUT_W=%0d", BIN_W, OUT_W);
  end

  logic [OUT_W-1:0] onehot;
  logic             range_err;

  logic [OUT_W-1:0] onehot_d, onehot_q;
  logic             err_d, err_q;
  logic             valid_d, valid_q;

  onehot_decode_comb #(
    .BIN_W (BIN_W),
    .OUT_W (OUT_W)
  ) u_decode (
    .bin_i       (bus.Bin),
    .onehot_o    (onehot),
    .range_err_o (range_err)
  );

  always_comb begin
    onehot_d = onehot_q;
    err_d    = err_q;
    valid_d  = valid_q;
    if (bus.en) begin
      onehot_d = onehot;
      err_d    = range_err;
      valid_d  = 1'b1;
    end
  end

  // Capture stage: the registered copy lags the sampled index by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.OneHotCode   = onehot;
  assign bus.range_err    = range_err;
  assign bus.OneHotCode_q = onehot_q;
  assign bus.valid_q      = valid_q;
  assign bus.err_q        = err_q;

endmodule

// File: tb/tb_bin_to_onehot_decoder.sv
// Scoreboard bench: default 3->8 decoder and a 3->6 decoder with out-of-range indices.
module tb_bin_to_onehot_decoder;
  import onehot_pkg::*;

  logic clk;
  logic rst_n;

  bin_to_onehot_decoder_if #(.BIN_W(3), .OUT_W(8)) d_if ();
  bin_to_onehot_decoder_if #(.BIN_W(3), .OUT_W(6)) s_if ();

  bin_to_onehot_decoder #(.BIN_W(3), .OUT_W(8)) dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d_if.slave)
  );

  bin_to_onehot_decoder #(.BIN_W(3), .OUT_W(6)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  // sel: 0 comb default, 1 reg default, 2 comb 6-line, 3 reg 6-line
  // comb layout {1'b0, onehot[7:0], range_err}; reg layout {onehot_q[7:0], valid_q, err_q}
  typedef struct {
    int         sel;
    logic [9:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pc(input int sel, input logic [7:0] oh, input logic err, input string name);
    exp_t e;
    e.sel = sel; e.exp = {1'b0, oh, err}; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic pr(input int sel, input logic [7:0] q, input logic v, input logic e_q,
                    input string name);
    exp_t e;
    e.sel = sel; e.exp = {q, v, e_q}; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the DUT on the falling edge.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sel)
          0:       act = {1'b0, d_if.OneHotCode, d_if.range_err};
          1:       act = {d_if.OneHotCode_q, d_if.valid_q, d_if.err_q};
          2:       act = {1'b0, 2'b00, s_if.OneHotCode, s_if.range_err};
          default: act = {2'b00, s_if.OneHotCode_q, s_if.valid_q, s_if.err_q};
        endcase
        checks++;
        if (act === e.exp) passed++;
        else $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        if ((e.sel == 0 || e.sel == 2) && e.exp[0] == 1'b0) begin
          checks++;
          if (is_onehot(256'(act[8:1]))) passed++;
          else $display("FAIL %s_popcount: got %b expected exactly one bit set", e.name, act[8:1]);
        end
      end
    end
  end

  logic [7:0] sweep_exp [8];
  logic [7:0] mq_d, mq_s;
  logic       mv_d, mv_s, me_d, me_s;
  logic [2:0] b;
  logic       en_r;

  initial begin
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0;
    d_if.Bin = '0; d_if.en = 1'b0;
    s_if.Bin = '0; s_if.en = 1'b0;

    step();
    pr(1, 8'h00, 1'b0, 1'b0, "reset_d");
    pr(3, 8'h00, 1'b0, 1'b0, "reset_s");
    step();
    rst_n = 1'b1;

    // Combinational sweep with en held low
    for (int i = 0; i < 8; i++) begin
      step();
      d_if.Bin = 3'(i);
      pc(0, sweep_exp[i], 1'b0, $sformatf("sweep_%0d", i));
      #1;
      $display("sweep Bin=%0d OneHotCode=%b expected=%b", i, d_if.OneHotCode, sweep_exp[i]);
    end
    step();
    pr(1, 8'h00, 1'b0, 1'b0, "sweep_no_capture");

    // Registered capture 3 then 6
    step(); d_if.en = 1'b1; d_if.Bin = 3'd3;
    step(); d_if.Bin = 3'd6; pr(1, 8'h08, 1'b1, 1'b0, "cap_3");
    step(); d_if.en = 1'b0;  pr(1, 8'h40, 1'b1, 1'b0, "cap_6");

    // Enable hold
    step(); d_if.en = 1'b1; d_if.Bin = 3'd5;
    step(); d_if.en = 1'b0; d_if.Bin = 3'd1;
    pr(1, 8'h20, 1'b1, 1'b0, "hold_q_a");
    pc(0, 8'h02, 1'b0, "hold_comb");
    step(); pr(1, 8'h20, 1'b1, 1'b0, "hold_q_b");

    // Async reset between edges with en high
    step(); d_if.en = 1'b1; d_if.Bin = 3'd7;
    step(); d_if.en = 1'b0; pr(1, 8'h80, 1'b1, 1'b0, "pre_reset_q");
    step(); #3; rst_n = 1'b0; d_if.en = 1'b1;
    pr(1, 8'h00, 1'b0, 1'b0, "async_reset_immediate");
    pc(0, 8'h80, 1'b0, "comb_during_reset");
    step(); pr(1, 8'h00, 1'b0, 1'b0, "reset_beats_en");
    step(); rst_n = 1'b1; pr(1, 8'h00, 1'b0, 1'b0, "release_no_capture");
    step(); pr(1, 8'h80, 1'b1, 1'b0, "first_capture_after_release");
    d_if.en = 1'b0;

    // Wrap 7 -> 0
    step(); d_if.en = 1'b1; d_if.Bin = 3'd7;
    step(); d_if.Bin = 3'd0; pr(1, 8'h80, 1'b1, 1'b0, "wrap_7");
    step(); d_if.en = 1'b0;  pr(1, 8'h01, 1'b1, 1'b0, "wrap_0");

    // Six-line decoder, out-of-range index
    step(); s_if.en = 1'b1; s_if.Bin = 3'd6;
    pc(2, 8'h00, 1'b1, "oor_6_comb");
    step(); s_if.Bin = 3'd5;
    pr(3, 8'h00, 1'b1, 1'b1, "oor_6_reg");
    pc(2, 8'h20, 1'b0, "inrange_5_comb");
    step(); s_if.en = 1'b0; s_if.Bin = 3'd7;
    pr(3, 8'h20, 1'b1, 1'b0, "inrange_5_reg");
    pc(2, 8'h00, 1'b1, "oor_7_comb");

    // Random property check on both decoders
    mq_d = 8'h01; mv_d = 1'b1; me_d = 1'b0;
    mq_s = 8'h20; mv_s = 1'b1; me_s = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      step();
      pr(1, mq_d, mv_d, me_d, "rand_reg_d");
      pr(3, mq_s, mv_s, me_s, "rand_reg_s");
      b    = 3'($urandom_range(0, 7));
      en_r = 1'($urandom_range(0, 1));
      d_if.Bin = b; d_if.en = en_r;
      s_if.Bin = b; s_if.en = en_r;
      pc(0, 8'(1) << b, 1'b0, "rand_comb_d");
      pc(2, (b < 3'd6) ? (8'(1) << b) : 8'h00, (b >= 3'd6), "rand_comb_s");
      if (en_r) begin
        mq_d = 8'(1) << b; mv_d = 1'b1; me_d = 1'b0;
        mq_s = (b < 3'd6) ? (8'(1) << b) : 8'h00; mv_s = 1'b1; me_s = (b >= 3'd6);
      end
    end
    step();
    pr(1, mq_d, mv_d, me_d, "rand_reg_d_last");
    pr(3, mq_s, mv_s, me_s, "rand_reg_s_last");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
